// File: rtl/plab1_imul_int_div_iter.sv
// Iterative 32-bit restoring divider for signed and unsigned quotient and remainder.
// The core takes one request at a time and answers 33 cycles after accepting it.
module plab1_imul_int_div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [66:0] in_msg,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_msg
);

  localparam int unsigned DW     = 32;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned CNT_W  = 5;

  localparam logic [FUNC_W-1:0] FN_DIV  = 3'd1;
  localparam logic [FUNC_W-1:0] FN_DIVU = 3'd2;
  localparam logic [FUNC_W-1:0] FN_REM  = 3'd3;
  localparam logic [FUNC_W-1:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [FUNC_W-1:0] func_q;
  logic              sign_a_q, sign_b_q, b_zero_q;
  logic [DW-1:0]     a_q, dvsr_q, rem_q, quo_q;

  logic [FUNC_W-1:0] req_func;
  logic [DW-1:0]     req_a, req_b;
  logic              req_signed;
  logic              in_go, out_go;

  assign req_func   = in_msg[66:64];
  assign req_a      = in_msg[63:32];
  assign req_b      = in_msg[31:0];
  assign req_signed = (req_func == FN_DIV) || (req_func == FN_REM);

  assign in_rdy  = !reset && (state_q == IDLE);
  assign out_val = !reset && (state_q == DONE);
  assign in_go   = in_val && in_rdy;
  assign out_go  = out_val && out_rdy;

  // Control state and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_go)
        cnt_q <= '0;
      else if (state_q == CALC)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_go) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(31)) state_d = DONE;
      DONE:    if (out_go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: the 33-bit partial remainder cannot overflow the compare
  logic [DW:0]   rem_sh;
  logic          rem_ge;
  logic [DW-1:0] rem_next;

  always_comb begin
    rem_sh   = {rem_q, quo_q[DW-1]};
    rem_ge   = rem_sh >= {1'b0, dvsr_q};
    rem_next = rem_ge ? DW'(rem_sh - {1'b0, dvsr_q}) : DW'(rem_sh);
  end

  always_ff @(posedge clk) begin
    if (in_go) begin
      func_q   <= req_func;
      a_q      <= req_a;
      sign_a_q <= req_a[DW-1];
      sign_b_q <= req_b[DW-1];
      b_zero_q <= (req_b == '0);
      quo_q    <= (req_signed && req_a[DW-1]) ? (~req_a + DW'(1)) : req_a;
      dvsr_q   <= (req_signed && req_b[DW-1]) ? (~req_b + DW'(1)) : req_b;
      rem_q    <= '0;
    end else if (state_q == CALC) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[DW-2:0], rem_ge};
    end
  end

  // Sign fix-up and divide-by-zero overrides on the held result
  logic [DW-1:0] quo_s, rem_s;

  always_comb begin
    quo_s   = (sign_a_q ^ sign_b_q) ? (~quo_q + DW'(1)) : quo_q;
    rem_s   = sign_a_q ? (~rem_q + DW'(1)) : rem_q;
    out_msg = '0;
    case (func_q)
      FN_DIV:  out_msg = b_zero_q ? '1  : quo_s;
      FN_DIVU: out_msg = b_zero_q ? '1  : quo_q;
      FN_REM:  out_msg = b_zero_q ? a_q : rem_s;
      FN_REMU: out_msg = b_zero_q ? a_q : rem_q;
      default: out_msg = '0;
    endcase
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({in_val, out_rdy, in_rdy, out_val}));

  a_msg_known: assert property (@(posedge clk) disable iff (reset)
    out_val |-> !$isunknown(out_msg));

endmodule

// File: tb/tb_plab1_imul_int_div_iter.sv
// Self-checking bench for the iterative divider: vector table, random unsigned/signed
// operands, backpressure and mid-operation reset, all scored through an expected-value queue.
module tb_plab1_imul_int_div_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [66:0] in_msg = '0;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [31:0] out_msg;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  plab1_imul_int_div_iter dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for in_rdy, presents one request for one cycle, records its expected result
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string name);
    int n = 0;
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_in_rdy"}, 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in_msg = {f, a, b};
    sb.push_back(exp);
    @(negedge clk);
    in_val = 1'b0;
  endtask

  // Called at the negedge of CALC cycle 1; waits for the response and scores it
  task automatic recv(input string name, input bit chk_lat);
    int k = 1;
    logic [31:0] exp;
    while (!out_val && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_out_val"}, 32'(out_val), 32'd1);
    if (chk_lat) check({name, "_latency"}, 32'(k), 32'd33);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_scoreboard: got response %h expected none", name, out_msg);
    end else begin
      exp = sb.pop_front();
      check({name, "_out_msg"}, out_msg, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb, re;
    logic signed [31:0] sa, sbv;
    logic [2:0]  rf;
    int          seen;

    tbl[0]  = '{3'd2, 32'd100,        32'd7,          32'd14};
    tbl[1]  = '{3'd4, 32'd100,        32'd7,          32'd2};
    tbl[2]  = '{3'd1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
    tbl[3]  = '{3'd3, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
    tbl[4]  = '{3'd2, 32'd5,          32'd0,          32'hFFFFFFFF};
    tbl[5]  = '{3'd3, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
    tbl[6]  = '{3'd1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    tbl[7]  = '{3'd3, 32'h80000000,   32'hFFFFFFFF,   32'd0};
    tbl[8]  = '{3'd1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF};
    tbl[9]  = '{3'd4, 32'd7,          32'd0,          32'd7};
    tbl[10] = '{3'd1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
    tbl[11] = '{3'd3, 32'd7,          32'hFFFFFFFE,   32'd1};
    tbl[12] = '{3'd1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3};
    tbl[13] = '{3'd3, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF};
    tbl[14] = '{3'd0, 32'd100,        32'd7,          32'd0};
    tbl[15] = '{3'd7, 32'd100,        32'd7,          32'd0};
    tbl[16] = '{3'd2, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF};
    tbl[17] = '{3'd4, 32'hFFFFFFFF,   32'd16,         32'h0000000F};
    tbl[18] = '{3'd2, 32'd3,          32'd7,          32'd0};
    tbl[19] = '{3'd2, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("reset_in_rdy", 32'(in_rdy), 32'd0);
    check("reset_out_val", 32'(out_val), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_rdy", 32'(in_rdy), 32'd1);
    check("post_reset_out_val", 32'(out_val), 32'd0);

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      send(tbl[i].func, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
      recv($sformatf("vec%0d", i), 1'b1);
    end

    // Random operands against a behavioural model (avoids b=0 and signed overflow)
    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      if (ra == 32'h80000000) ra = 32'd1;
      sa = ra;
      sbv = rb;
      case (rf)
        3'd1:    re = 32'(sa / sbv);
        3'd2:    re = ra / rb;
        3'd3:    re = 32'(sa % sbv);
        default: re = ra % rb;
      endcase
      send(rf, ra, rb, re, $sformatf("rnd%0d", i));
      recv($sformatf("rnd%0d", i), 1'b1);
    end

    // Backpressure with in_val held high throughout
    out_rdy = 1'b0;
    check("bp_in_rdy", 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in_msg = {3'd2, 32'd100, 32'd7};
    sb.push_back(32'd14);
    @(negedge clk);
    in_msg = {3'd2, 32'd50, 32'd5};
    begin
      int k = 1;
      while (!out_val && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("bp_latency", 32'(k), 32'd33);
    end
    held = out_msg;
    check("bp_first_msg", held, 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_val", i), 32'(out_val), 32'd1);
      check($sformatf("bp_hold%0d_msg", i), out_msg, held);
      check($sformatf("bp_hold%0d_in_rdy", i), 32'(in_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    check("bp_release_in_rdy", 32'(in_rdy), 32'd0);
    if (sb.size() != 0) check("bp_out_msg", out_msg, sb.pop_front());
    @(negedge clk);
    check("bp_idle_in_rdy", 32'(in_rdy), 32'd1);
    check("bp_idle_out_val", 32'(out_val), 32'd0);
    sb.push_back(32'd10);
    @(negedge clk);
    in_val = 1'b0;
    recv("bp_next", 1'b1);

    // Reset in CALC cycle 10 aborts the request
    send(3'd2, 32'd100, 32'd7, 32'd14, "abort");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rst_in_rdy", 32'(in_rdy), 32'd0);
    check("abort_rst_out_val", 32'(out_val), 32'd0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_post_in_rdy", 32'(in_rdy), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_val) seen++;
      @(negedge clk);
    end
    check("abort_no_response", 32'(seen), 32'd0);
    send(3'd2, 32'd9, 32'd3, 32'd3, "after_abort");
    recv("after_abort", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
